// File: rtl/alu_issue_sequencer.sv
// Issue stage for the 8-bit ALU: accepts one instruction per handshake, reads a 4-entry
// register file into the ALU operand registers, waits out the ALU latency and writes the result back.
module alu_issue_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [19:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    output logic [1:0]        res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [1:0]        rd_q;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_sel_q;
    logic              res_valid_q;
    logic [1:0]        res_rd_q;
    logic [DATA_W-1:0] res_data_q;

    logic [3:0]        f_sel;
    logic [1:0]        f_rd;
    logic [1:0]        f_rs1;
    logic [1:0]        f_rs2;
    logic              f_ldi;
    logic [DATA_W-1:0] f_imm;
    logic              accept;
    logic              unused_rsvd;

    assign f_sel       = instr[19:16];
    assign f_rd        = instr[15:14];
    assign f_rs1       = instr[13:12];
    assign f_rs2       = instr[11:10];
    assign f_ldi       = instr[9];
    assign unused_rsvd = instr[8];
    assign f_imm       = DATA_W'(instr[7:0]);

    assign instr_ready = (state_q == IDLE);
    assign accept      = instr_valid && (state_q == IDLE);

    // Sequencer FSM, register file, ALU operand registers and write-back pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rd_q        <= 2'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= 4'd0;
            res_valid_q <= 1'b0;
            res_rd_q    <= 2'd0;
            res_data_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (f_ldi) begin
                            rf_q[f_rd]  <= f_imm;
                            res_valid_q <= 1'b1;
                            res_rd_q    <= f_rd;
                            res_data_q  <= f_imm;
                        end else begin
                            alu_a_q   <= rf_q[f_rs1];
                            alu_b_q   <= rf_q[f_rs2];
                            alu_sel_q <= f_sel;
                            rd_q      <= f_rd;
                            cnt_q     <= 3'(ALU_LAT);
                            state_q   <= WAIT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    // The counter hits zero on the first edge at which ALU_out carries this result.
                    if (cnt_q == 3'd0) begin
                        rf_q[rd_q]  <= alu_result;
                        res_valid_q <= 1'b1;
                        res_rd_q    <= rd_q;
                        res_data_q  <= alu_result;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_rd    = res_rd_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q == WAIT);

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: two instances (ALU latency 1 and 3) behind registered stub ALUs,
// a queue-based reference model of the register file, and a negedge monitor acting as scoreboard.
module tb_alu_issue_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;

    logic [19:0] instr_v   [2];
    logic        valid_v   [2];
    logic        ready_v   [2];
    logic [7:0]  alu_a_v   [2];
    logic [7:0]  alu_b_v   [2];
    logic [3:0]  alu_sel_v [2];
    logic [7:0]  alu_res_v [2];
    logic        rv_v      [2];
    logic [1:0]  rrd_v     [2];
    logic [7:0]  rdata_v   [2];
    logic        busy_v    [2];

    typedef struct { int lane; int cyc; logic [1:0] rd; logic [7:0] data; } res_t;
    typedef struct { int lane; int cyc; logic [7:0] a; logic [7:0] b; logic [3:0] sel; } iss_t;

    res_t       res_q [$];
    iss_t       iss_q [$];
    logic [7:0] rf_m [2][4];
    logic [7:0] held_a [2];
    logic [7:0] held_b [2];
    logic [3:0] held_sel [2];
    int         busy_from [2];
    int         busy_to [2];
    int         free_edge [2];
    logic [7:0] last_data [2];
    logic [1:0] last_rd [2];
    int         lat_of [2] = '{1, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        case (s)
            4'h0:    return a + b;
            4'h1:    return a * b;
            4'h7:    return {a[0], a[7:1]};
            4'hF:    return (a < b) ? 8'h01 : 8'h00;
            default: return a ^ b;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int L = (g == 0) ? 1 : 3;
        logic [7:0] pipe [L];

        alu_issue_sequencer #(.DATA_W(8), .ALU_LAT(L)) dut (
            .clk(clk), .rst_n(rst_n), .instr(instr_v[g]), .instr_valid(valid_v[g]),
            .instr_ready(ready_v[g]), .alu_a(alu_a_v[g]), .alu_b(alu_b_v[g]),
            .alu_sel(alu_sel_v[g]), .alu_result(alu_res_v[g]), .res_valid(rv_v[g]),
            .res_rd(rrd_v[g]), .res_data(rdata_v[g]), .busy(busy_v[g])
        );

        // Registered stub ALU with L pipeline stages.
        always @(posedge clk) begin
            pipe[0] <= alu_fn(alu_a_v[g], alu_b_v[g], alu_sel_v[g]);
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign alu_res_v[g] = pipe[L-1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s @cyc %0d", name, cyc);
    endtask

    function automatic logic [19:0] ldi_i(input logic [1:0] rd, input logic [7:0] imm);
        return {4'h0, rd, 2'b00, 2'b00, 1'b1, 1'b0, imm};
    endfunction

    function automatic logic [19:0] alu_i(input logic [3:0] s, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2);
        return {s, rd, rs1, rs2, 1'b0, 1'b0, 8'h00};
    endfunction

    task automatic model_reset();
        res_q.delete();
        iss_q.delete();
        for (int l = 0; l < 2; l++) begin
            for (int r = 0; r < 4; r++) rf_m[l][r] = 8'h00;
            held_a[l] = 8'h00; held_b[l] = 8'h00; held_sel[l] = 4'h0;
            busy_from[l] = 1; busy_to[l] = 0; free_edge[l] = 0;
        end
    endtask

    // Reference behaviour of one accepted instruction whose accept edge is e.
    task automatic model_apply(input int l, input logic [19:0] ins, input int e);
        logic [7:0] a, b, r;
        if (ins[9]) begin
            rf_m[l][ins[15:14]] = ins[7:0];
            res_q.push_back('{lane: l, cyc: e, rd: ins[15:14], data: ins[7:0]});
        end else begin
            a = rf_m[l][ins[13:12]];
            b = rf_m[l][ins[11:10]];
            r = alu_fn(a, b, ins[19:16]);
            rf_m[l][ins[15:14]] = r;
            iss_q.push_back('{lane: l, cyc: e, a: a, b: b, sel: ins[19:16]});
            res_q.push_back('{lane: l, cyc: e + lat_of[l] + 1, rd: ins[15:14], data: r});
            busy_from[l] = e;
            busy_to[l]   = e + lat_of[l];
            free_edge[l] = e + lat_of[l] + 2;
        end
    endtask

    task automatic send(input int l, input logic [19:0] ins);
        int first, e, w;
        @(negedge clk);
        instr_v[l] = ins;
        valid_v[l] = 1'b1;
        first = cyc + 1;
        w = 0;
        while (!ready_v[l] && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (!ready_v[l]) begin
            note_fail("accept_timeout");
            valid_v[l] = 1'b0;
        end else begin
            e = cyc + 1;
            chk("accept_edge", e, (first > free_edge[l]) ? first : free_edge[l]);
            model_apply(l, ins, e);
            @(posedge clk);
            #1 valid_v[l] = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (res_q.size() > 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (res_q.size() > 0) note_fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: write-back pulses, held ALU inputs, busy/ready windows.
    always @(negedge clk) begin
        if (rst_n) begin
            while (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
                held_a[iss_q[0].lane]   = iss_q[0].a;
                held_b[iss_q[0].lane]   = iss_q[0].b;
                held_sel[iss_q[0].lane] = iss_q[0].sel;
                void'(iss_q.pop_front());
            end
            while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
                note_fail("res_missing");
                void'(res_q.pop_front());
            end
            for (int l = 0; l < 2; l++) begin
                logic eb;
                eb = (cyc >= busy_from[l]) && (cyc <= busy_to[l]);
                chk("busy", busy_v[l], eb);
                chk("ready", ready_v[l], !eb);
                chk("alu_a", alu_a_v[l], held_a[l]);
                chk("alu_b", alu_b_v[l], held_b[l]);
                chk("alu_sel", alu_sel_v[l], held_sel[l]);
                if (rv_v[l]) begin
                    if (res_q.size() > 0 && res_q[0].lane == l && res_q[0].cyc == cyc) begin
                        chk("res_rd", rrd_v[l], res_q[0].rd);
                        chk("res_data", rdata_v[l], res_q[0].data);
                        last_rd[l]   = rrd_v[l];
                        last_data[l] = rdata_v[l];
                        void'(res_q.pop_front());
                    end else begin
                        note_fail("res_unexpected");
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] ins;
        model_reset();
        for (int l = 0; l < 2; l++) begin
            instr_v[l] = 20'h0;
            valid_v[l] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int l = 0; l < 2; l++) begin
            chk("rst_ready", ready_v[l], 1'b1);
            chk("rst_busy", busy_v[l], 1'b0);
            chk("rst_res_valid", rv_v[l], 1'b0);
            chk("rst_res_rd", rrd_v[l], 2'd0);
            chk("rst_res_data", rdata_v[l], 8'h00);
            chk("rst_alu", {alu_a_v[l], alu_b_v[l], alu_sel_v[l]}, 20'h0);
        end

        // LDI, LDI, ADD with directed timing points
        send(0, ldi_i(2'd1, 8'h4D));
        send(0, ldi_i(2'd2, 8'h17));
        send(0, alu_i(4'h0, 2'd3, 2'd1, 2'd2));
        @(negedge clk);
        chk("add_issue_a", alu_a_v[0], 8'h4D);
        chk("add_issue_b", alu_b_v[0], 8'h17);
        chk("add_issue_sel", alu_sel_v[0], 4'h0);
        @(negedge clk);
        chk("add_no_early_res", rv_v[0], 1'b0);
        @(negedge clk);
        chk("add_res_valid", rv_v[0], 1'b1);
        chk("add_res_rd", rrd_v[0], 2'd3);
        chk("add_res_data", rdata_v[0], 8'h64);

        // Back-pressure: second ADD offered during WAIT
        send(0, alu_i(4'h0, 2'd0, 2'd3, 2'd1));
        send(0, alu_i(4'h0, 2'd2, 2'd3, 2'd3));
        drain();
        chk("r3_kept", last_data[0], 8'hC8);

        // Self-overwrite then dependent ADD
        send(0, ldi_i(2'd1, 8'h4D));
        send(0, alu_i(4'h0, 2'd1, 2'd1, 2'd1));
        send(0, ldi_i(2'd2, 8'h17));
        send(0, alu_i(4'h0, 2'd0, 2'd1, 2'd2));
        drain();
        chk("selfow_dep_rd", last_rd[0], 2'd0);
        chk("selfow_dep_data", last_data[0], 8'hB1);

        // Pass-through LTH with reserved bit set, then LDI leaves ALU inputs alone
        send(0, {4'hF, 2'd3, 2'd0, 2'd1, 1'b0, 1'b1, 8'hAA});
        send(0, {4'h5, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 8'h5A});
        @(negedge clk);
        chk("lth_sel_held", alu_sel_v[0], 4'hF);
        drain();

        for (int i = 0; i < 150; i++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            send(0, ins);
        end
        drain();

        // ALU_LAT=3 lane: ROR
        send(1, ldi_i(2'd0, 8'h81));
        send(1, alu_i(4'h7, 2'd2, 2'd0, 2'd0));
        drain();
        chk("ror_rd", last_rd[1], 2'd2);
        chk("ror_data", last_data[1], 8'hC0);

        for (int i = 0; i < 60; i++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            send(1, ins);
        end
        drain();

        // Asynchronous reset during WAIT
        send(1, ldi_i(2'd1, 8'h3C));
        send(1, alu_i(4'h0, 2'd3, 2'd1, 2'd1));
        @(negedge clk);
        chk("pre_rst_busy", busy_v[1], 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_busy", busy_v[1], 1'b0);
        chk("arst_ready", ready_v[1], 1'b1);
        chk("arst_alu", {alu_a_v[1], alu_b_v[1], alu_sel_v[1]}, 20'h0);
        chk("arst_res", {rv_v[1], rrd_v[1], rdata_v[1]}, 11'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", ready_v[1], 1'b1);
        send(1, ldi_i(2'd0, 8'hFF));
        drain();
        chk("post_rst_ldi_rd", last_rd[1], 2'd0);
        chk("post_rst_ldi_data", last_data[1], 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
